io_port_controller: RTL

//   Memory-mapped I/O controller between the single-cycle CPU data bus and the board I/O.

---
 rtl/io_port_controller_if.sv | 20 ++
 rtl/io_port_controller.sv | 134 +++++++++++++
 2 files changed

// File: rtl/io_port_controller_if.sv
// CPU data-bus bundle between the core and the memory-mapped I/O controller.
// The CPU drives address, data and strobes; the controller returns read data and its select.
interface io_port_controller_if;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_we;
    logic        cpu_rd;
    logic [31:0] cpu_rdata;
    logic        io_sel;

    modport master (
        output cpu_addr, cpu_wdata, cpu_we, cpu_rd,
        input  cpu_rdata, io_sel
    );

    modport slave (
        input  cpu_addr, cpu_wdata, cpu_we, cpu_rd,
        output cpu_rdata, io_sel
    );
endinterface

// File: rtl/io_port_controller.sv
// Memory-mapped I/O window: debounced switch input, sticky change flag, two CPU output registers.
// Window occupies 16 bytes at BASE_ADDR; word offset selects IN0/STAT/OUT0/OUT1.
module io_port_controller #(
    parameter int unsigned IN_W       = 8,
    parameter int unsigned DEB_CYCLES = 16,
    parameter logic [31:0] BASE_ADDR  = 32'h80
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic [IN_W-1:0]     switch,
    io_port_controller_if.slave bus,
    output logic [31:0]         out_port0,
    output logic [31:0]         out_port1,
    output logic                out_update
);

    localparam int unsigned CntW = $clog2(DEB_CYCLES);
    localparam logic [CntW-1:0] CntMax = CntW'(DEB_CYCLES - 1);

    typedef enum logic [0:0] {StStable, StCounting} state_e;

    state_e          state_q, state_d;
    logic [IN_W-1:0] sync1_q, sync2_q;
    logic [IN_W-1:0] stable_q, stable_d;
    logic [IN_W-1:0] cand_q, cand_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            chg_q, chg_d;
    logic [31:0]     out0_q, out1_q;
    logic            upd_q;

    logic [IN_W-1:0] sw_s;
    logic            accept;
    logic            sel;
    logic [1:0]      offset;
    logic            wr_out0, wr_out1, stat_clr;
    logic [31:0]     in0_word;
    logic [31:0]     rdata;
    logic [1:0]      unused_addr;

    assign sw_s        = sync2_q;
    assign sel         = (bus.cpu_addr[31:4] == BASE_ADDR[31:4]);
    assign offset      = bus.cpu_addr[3:2];
    assign unused_addr = bus.cpu_addr[1:0];
    assign wr_out0     = sel & bus.cpu_we & (offset == 2'd2);
    assign wr_out1     = sel & bus.cpu_we & (offset == 2'd3);
    assign stat_clr    = sel & bus.cpu_rd & (offset == 2'd1);

    // Whole-vector debounce: candidate must persist DEB_CYCLES cycles after entering COUNTING.
    always_comb begin
        state_d  = state_q;
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        stable_d = stable_q;
        accept   = 1'b0;
        unique case (state_q)
            StStable: begin
                if (sw_s != stable_q) begin
                    cand_d  = sw_s;
                    cnt_d   = '0;
                    state_d = StCounting;
                end
            end
            StCounting: begin
                if (sw_s == stable_q) begin
                    state_d = StStable;
                end else if (sw_s != cand_q) begin
                    cand_d = sw_s;
                    cnt_d  = '0;
                end else if (cnt_q == CntMax) begin
                    stable_d = cand_q;
                    accept   = 1'b1;
                    state_d  = StStable;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StStable;
        endcase
    end

    // A new acceptance wins over a concurrent STAT read clear.
    assign chg_d = accept | (chg_q & ~stat_clr);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q  <= StStable;
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            cand_q   <= '0;
            cnt_q    <= '0;
            chg_q    <= 1'b0;
            out0_q   <= '0;
            out1_q   <= '0;
            upd_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sync1_q  <= switch;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cand_q   <= cand_d;
            cnt_q    <= cnt_d;
            chg_q    <= chg_d;
            upd_q    <= wr_out0 | wr_out1;
            if (wr_out0) begin
                out0_q <= bus.cpu_wdata;
            end
            if (wr_out1) begin
                out1_q <= bus.cpu_wdata;
            end
        end
    end

    always_comb begin
        in0_word           = '0;
        in0_word[IN_W-1:0] = stable_q;
        rdata              = '0;
        if (sel) begin
            unique case (offset)
                2'd0:    rdata = in0_word;
                2'd1:    rdata = {31'b0, chg_q};
                2'd2:    rdata = out0_q;
                default: rdata = out1_q;
            endcase
        end
    end

    assign bus.cpu_rdata = rdata;
    assign bus.io_sel    = sel;
    assign out_port0     = out0_q;
    assign out_port1     = out1_q;
    assign out_update    = upd_q;

endmodule
